// File: rtl/moving_avg_mc_if.sv
// Sample/result bundle for moving_avg_mc: the driver holds the master side, the filter the slave.
// Sizes follow the filter's CHANNELS / DATA_W / LOG2_WIN parameters.
interface moving_avg_mc_if #(
   parameter int unsigned CHANNELS = 3,
   parameter int unsigned DATA_W   = 2,
   parameter int unsigned LOG2_WIN = 2
);
   localparam int unsigned AW = DATA_W + LOG2_WIN;

   logic                       clr;
   logic                       in_valid;
   logic [CHANNELS*DATA_W-1:0] in_data;
   logic                       mode;
   logic                       out_en;
   logic                       out_valid;
   logic [CHANNELS*AW-1:0]     out_data;
   logic [LOG2_WIN:0]          fill;
   logic                       full;

   modport master (
      output clr, in_valid, in_data, mode, out_en,
      input  out_valid, out_data, fill, full
   );

   modport slave (
      input  clr, in_valid, in_data, mode, out_en,
      output out_valid, out_data, fill, full
   );
endinterface

// File: rtl/moving_avg_mc.sv
// Multi-channel moving sum / average over a 2**LOG2_WIN sample window, one-cycle latency.
// Accumulators are DATA_W+LOG2_WIN bits wide, enough for a full window of maximum samples.
module moving_avg_mc #(
   parameter int unsigned CHANNELS = 3,
   parameter int unsigned DATA_W   = 2,
   parameter int unsigned LOG2_WIN = 2
) (
   input logic            clk,
   input logic            rst_n,
   moving_avg_mc_if.slave bus
);
   localparam int unsigned WIN = 2 ** LOG2_WIN;
   localparam int unsigned AW  = DATA_W + LOG2_WIN;
   localparam int unsigned FW  = LOG2_WIN + 1;

   logic [DATA_W-1:0]      win_q [CHANNELS][WIN];
   logic [DATA_W-1:0]      win_d [CHANNELS][WIN];
   logic [AW-1:0]          acc_q [CHANNELS];
   logic [AW-1:0]          acc_d [CHANNELS];
   logic [CHANNELS*AW-1:0] res_q, res_d;
   logic [FW-1:0]          fill_q, fill_d;
   logic                   full_q, full_d;
   logic                   vld_q, vld_d;
   logic [DATA_W-1:0]      sample;

   always_comb begin
      win_d  = win_q;
      acc_d  = acc_q;
      res_d  = res_q;
      fill_d = fill_q;
      full_d = full_q;
      vld_d  = 1'b0;
      sample = '0;
      if (bus.clr) begin
         // Clear wins over a simultaneous sample, which is dropped.
         for (int c = 0; c < int'(CHANNELS); c++) begin
            for (int i = 0; i < int'(WIN); i++) begin
               win_d[c][i] = '0;
            end
            acc_d[c] = '0;
         end
         res_d  = '0;
         fill_d = '0;
         full_d = 1'b0;
      end else if (bus.in_valid) begin
         vld_d = 1'b1;
         for (int c = 0; c < int'(CHANNELS); c++) begin
            sample   = bus.in_data[c*DATA_W +: DATA_W];
            acc_d[c] = acc_q[c] + AW'(sample) - AW'(win_q[c][WIN-1]);
            for (int i = 1; i < int'(WIN); i++) begin
               win_d[c][i] = win_q[c][i-1];
            end
            win_d[c][0] = sample;
            res_d[c*AW +: AW] = bus.mode ? (acc_d[c] >> LOG2_WIN) : acc_d[c];
         end
         if (fill_q != FW'(WIN)) begin
            fill_d = fill_q + FW'(1);
         end
         full_d = (fill_d == FW'(WIN));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < int'(CHANNELS); c++) begin
            for (int i = 0; i < int'(WIN); i++) begin
               win_q[c][i] <= '0;
            end
            acc_q[c] <= '0;
         end
         res_q  <= '0;
         fill_q <= '0;
         full_q <= 1'b0;
         vld_q  <= 1'b0;
      end else begin
         win_q  <= win_d;
         acc_q  <= acc_d;
         res_q  <= res_d;
         fill_q <= fill_d;
         full_q <= full_d;
         vld_q  <= vld_d;
      end
   end

   assign bus.out_data  = bus.out_en ? res_q : '0;
   assign bus.out_valid = vld_q;
   assign bus.fill      = fill_q;
   assign bus.full      = full_q;
endmodule

// File: tb/tb_moving_avg_mc.sv
// Self-checking bench for moving_avg_mc against a queue-based window model.
// Directed scenarios first, then a randomized stream with occasional clears.
module tb_moving_avg_mc;
   localparam int unsigned CH  = 3;
   localparam int unsigned DW  = 2;
   localparam int unsigned LW  = 2;
   localparam int unsigned WIN = 4;
   localparam int unsigned AW  = DW + LW;
   localparam int unsigned IW  = CH * DW;
   localparam int unsigned OW  = CH * AW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   moving_avg_mc_if #(.CHANNELS(CH), .DATA_W(DW), .LOG2_WIN(LW)) bus ();

   moving_avg_mc #(.CHANNELS(CH), .DATA_W(DW), .LOG2_WIN(LW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   int            hist [CH][$];
   int            cnt;
   logic [OW-1:0] exp_res;
   logic          exp_vld;

   function automatic logic [OW-1:0] exp_out();
      return bus.out_en ? exp_res : '0;
   endfunction

   function automatic logic [IW-1:0] pack(input int c2, input int c1, input int c0);
      return {DW'(c2), DW'(c1), DW'(c0)};
   endfunction

   task automatic model_clear();
      for (int c = 0; c < int'(CH); c++) hist[c].delete();
      cnt     = 0;
      exp_res = '0;
      exp_vld = 1'b0;
   endtask

   // Captures the inputs presented before the edge, advances one clock, updates the model.
   task automatic cycle();
      logic          acc;
      logic          cl;
      logic          m;
      logic [IW-1:0] d;
      acc = bus.in_valid && !bus.clr;
      cl  = bus.clr;
      m   = bus.mode;
      d   = bus.in_data;
      @(posedge clk);
      #1;
      if (cl) begin
         model_clear();
      end else if (acc) begin
         for (int c = 0; c < int'(CH); c++) begin
            int s = 0;
            hist[c].push_back(int'(d[c*DW +: DW]));
            if (hist[c].size() > int'(WIN)) void'(hist[c].pop_front());
            foreach (hist[c][k]) s += hist[c][k];
            exp_res[c*AW +: AW] = AW'(m ? s / int'(WIN) : s);
         end
         if (cnt < int'(WIN)) cnt++;
      end
      exp_vld = acc;
   endtask

   task automatic test_reset();
      #3;
      checks += 4;
      if (bus.out_data !== '0) begin
         failures++; $display("FAIL reset_data got=%h exp=0", bus.out_data);
      end
      if (bus.out_valid !== 1'b0) begin
         failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid);
      end
      if (bus.fill !== '0) begin
         failures++; $display("FAIL reset_fill got=%0d exp=0", bus.fill);
      end
      if (bus.full !== 1'b0) begin
         failures++; $display("FAIL reset_full got=%b exp=0", bus.full);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
   endtask

   task automatic test_fill_sum();
      int exp0 [4] = '{3, 6, 9, 12};
      bus.mode = 1'b0; bus.in_valid = 1'b1; bus.in_data = pack(0, 1, 3);
      for (int i = 0; i < 4; i++) begin
         cycle();
         checks += 6;
         if (bus.out_data[AW-1:0] !== AW'(exp0[i])) begin
            failures++; $display("FAIL fill_ch0 step=%0d got=%0d exp=%0d", i, bus.out_data[AW-1:0], exp0[i]);
         end
         if (bus.out_data[AW +: AW] !== AW'(i + 1)) begin
            failures++; $display("FAIL fill_ch1 step=%0d got=%0d exp=%0d", i, bus.out_data[AW +: AW], i + 1);
         end
         if (bus.out_data !== exp_out()) begin
            failures++; $display("FAIL fill_data got=%h exp=%h", bus.out_data, exp_out());
         end
         if (bus.out_valid !== 1'b1) begin
            failures++; $display("FAIL fill_valid got=%b exp=1", bus.out_valid);
         end
         if (bus.fill !== 3'(i + 1)) begin
            failures++; $display("FAIL fill_count got=%0d exp=%0d", bus.fill, i + 1);
         end
         if (bus.full !== (i == 3)) begin
            failures++; $display("FAIL fill_full step=%0d got=%b", i, bus.full);
         end
      end
   endtask

   task automatic test_slide();
      int exp0 [4] = '{9, 6, 3, 0};
      bus.in_data = pack(0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         checks += 3;
         if (bus.out_data[AW-1:0] !== AW'(exp0[i])) begin
            failures++; $display("FAIL slide_ch0 step=%0d got=%0d exp=%0d", i, bus.out_data[AW-1:0], exp0[i]);
         end
         if (bus.out_data !== exp_out()) begin
            failures++; $display("FAIL slide_data got=%h exp=%h", bus.out_data, exp_out());
         end
         if (bus.fill !== 3'd4) begin
            failures++; $display("FAIL slide_fill got=%0d exp=4", bus.fill);
         end
      end
      bus.in_data = pack(3, 3, 3);
      for (int i = 0; i < 4; i++) cycle();
      checks++;
      if (bus.out_data !== {AW'(12), AW'(12), AW'(12)}) begin
         failures++; $display("FAIL max_sum got=%h exp=ccc", bus.out_data);
      end
   endtask

   task automatic test_avg();
      int smp [4] = '{3, 3, 2, 0};
      int exp0 [4] = '{0, 1, 2, 2};
      bus.clr = 1'b1; bus.in_valid = 1'b0;
      cycle();
      bus.clr = 1'b0; bus.in_valid = 1'b1; bus.mode = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_data = pack(1, 2, smp[i]);
         cycle();
         checks += 2;
         if (bus.out_data[AW-1:0] !== AW'(exp0[i])) begin
            failures++; $display("FAIL avg_ch0 step=%0d got=%0d exp=%0d", i, bus.out_data[AW-1:0], exp0[i]);
         end
         if (bus.out_data !== exp_out()) begin
            failures++; $display("FAIL avg_data got=%h exp=%h", bus.out_data, exp_out());
         end
      end
   endtask

   task automatic test_gating_idle();
      logic [OW-1:0] held;
      bus.mode = 1'b0; bus.in_data = pack(2, 1, 3); bus.out_en = 1'b0;
      cycle();
      checks += 3;
      if (bus.out_data !== '0) begin
         failures++; $display("FAIL gate_off got=%h exp=0", bus.out_data);
      end
      if (bus.out_valid !== 1'b1) begin
         failures++; $display("FAIL gate_valid got=%b exp=1", bus.out_valid);
      end
      bus.out_en = 1'b1;
      #1;
      if (bus.out_data !== exp_out() || exp_res === '0) begin
         failures++; $display("FAIL gate_on got=%h exp=%h", bus.out_data, exp_out());
      end
      held = exp_res;
      bus.in_valid = 1'b0; bus.mode = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         checks += 2;
         if (bus.out_data !== held) begin
            failures++; $display("FAIL idle_data got=%h exp=%h", bus.out_data, held);
         end
         if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL idle_valid got=%b exp=0", bus.out_valid);
         end
      end
   endtask

   task automatic test_clear();
      bus.clr = 1'b1; bus.in_valid = 1'b1; bus.in_data = pack(3, 3, 3);
      cycle();
      checks += 4;
      if (bus.fill !== '0) begin
         failures++; $display("FAIL clr_fill got=%0d exp=0", bus.fill);
      end
      if (bus.full !== 1'b0) begin
         failures++; $display("FAIL clr_full got=%b exp=0", bus.full);
      end
      if (bus.out_data !== '0) begin
         failures++; $display("FAIL clr_data got=%h exp=0", bus.out_data);
      end
      if (bus.out_valid !== 1'b0) begin
         failures++; $display("FAIL clr_valid got=%b exp=0", bus.out_valid);
      end
      bus.clr = 1'b0; bus.mode = 1'b0; bus.in_data = pack(0, 0, 2);
      cycle();
      checks += 2;
      if (bus.out_data[AW-1:0] !== AW'(2)) begin
         failures++; $display("FAIL clr_next_ch0 got=%0d exp=2", bus.out_data[AW-1:0]);
      end
      if (bus.fill !== 3'd1) begin
         failures++; $display("FAIL clr_next_fill got=%0d exp=1", bus.fill);
      end
   endtask

   task automatic test_async_reset();
      bus.in_data = pack(1, 2, 3);
      cycle();
      cycle();
      checks++;
      if (bus.fill !== 3'd3) begin
         failures++; $display("FAIL ares_pre_fill got=%0d exp=3", bus.fill);
      end
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks += 3;
      if (bus.out_data !== '0) begin
         failures++; $display("FAIL ares_data got=%h exp=0", bus.out_data);
      end
      if (bus.fill !== '0) begin
         failures++; $display("FAIL ares_fill got=%0d exp=0", bus.fill);
      end
      if (bus.out_valid !== 1'b0) begin
         failures++; $display("FAIL ares_valid got=%b exp=0", bus.out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      bus.in_valid = 1'b1; bus.in_data = pack(0, 0, 1);
      cycle();
      checks += 2;
      if (bus.out_data[AW-1:0] !== AW'(1)) begin
         failures++; $display("FAIL ares_next_ch0 got=%0d exp=1", bus.out_data[AW-1:0]);
      end
      if (bus.fill !== 3'd1) begin
         failures++; $display("FAIL ares_next_fill got=%0d exp=1", bus.fill);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         bus.in_valid = ($urandom_range(0, 3) != 0);
         bus.clr      = ($urandom_range(0, 15) == 0);
         bus.in_data  = IW'($urandom);
         bus.mode     = 1'($urandom);
         bus.out_en   = ($urandom_range(0, 7) != 0);
         cycle();
         checks += 4;
         if (bus.out_data !== exp_out()) begin
            failures++; $display("FAIL rand_data n=%0d got=%h exp=%h", n, bus.out_data, exp_out());
         end
         if (bus.out_valid !== exp_vld) begin
            failures++; $display("FAIL rand_valid n=%0d got=%b exp=%b", n, bus.out_valid, exp_vld);
         end
         if (bus.fill !== 3'(cnt)) begin
            failures++; $display("FAIL rand_fill n=%0d got=%0d exp=%0d", n, bus.fill, cnt);
         end
         if (bus.full !== (cnt == int'(WIN))) begin
            failures++; $display("FAIL rand_full n=%0d got=%b exp=%b", n, bus.full, cnt == int'(WIN));
         end
      end
   endtask

   initial begin
      bus.clr = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
      bus.mode = 1'b0; bus.out_en = 1'b1;
      model_clear();
      test_reset();
      test_fill_sum();
      test_slide();
      test_avg();
      test_gating_idle();
      test_clear();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/moving_avg_mc.md
Name: moving_avg_mc

Overview:
- Parametrised multi-channel moving-sum / moving-average filter over a power-of-two sliding window.
- Successor to the fixed 3-channel, 2-bit, 4-deep window block, adding:
  - full-width accumulators that cannot overflow,
  - a selectable sum/average mode,
  - a valid handshake, a synchronous clear, and window-fill status.
- Sits behind the top-level pin wrapper: packed inputs come from ui_in, results drive uo_out.

Parameters:
- CHANNELS, 3, number of independent channels sharing one window/valid.
- DATA_W, 2, unsigned sample width per channel.
- LOG2_WIN, 2, window depth WIN = 2**LOG2_WIN (legal 1..6).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear of window, accumulators, fill count and outputs.
- in_valid  in  1  sample strobe; one sample per channel accepted per cycle when high.
- in_data  in  CHANNELS*DATA_W  packed samples; channel k occupies bits [k*DATA_W +: DATA_W].
- mode  in  1  0 = output window sum; 1 = output window average (sum >> LOG2_WIN).
- out_en  in  1  output gate; when 0, out_data reads all zeros.
- out_valid  out  1  one-cycle pulse, one cycle after each accepted sample.
- out_data  out  CHANNELS*(DATA_W+LOG2_WIN)  packed results; channel k occupies bits [k*AW +: AW], where AW = DATA_W+LOG2_WIN.
- fill  out  LOG2_WIN+1  number of valid samples in the window, saturating at WIN.
- full  out  1  fill == WIN.

Behaviour:
Reset and clear:
- rst_n low: asynchronously clear all window entries, accumulators, the result register, fill, out_valid and full to 0.
- clr high at a clock edge: same clear, synchronously.
- clr has priority over a simultaneous in_valid; that sample is dropped and out_valid stays 0.

Window and accumulator:
- Each channel has a WIN-entry shift window and an AW-bit accumulator.
- On an accepted sample (in_valid=1, clr=0): per channel, acc <= acc + new - oldest; the window shifts, oldest is discarded, new enters the youngest slot.
- All arithmetic is AW bits wide; the accumulator always stays in 0..WIN*(2**DATA_W-1), so no wrap can occur.
- Empty slots hold 0. During fill the sum covers only the samples received so far.

Result register and latency:
- On the same edge as the accumulator update, the result register loads the new acc values, post-processed by mode.
- mode=1: result = acc >> LOG2_WIN (truncating), zero-extended to AW. This divides by WIN even before the window is full; the startup ramp is intentional.
- mode is sampled at the accept edge. Changing mode without a new sample does not update out_data.
- out_valid = 1 for exactly the cycle following the accept edge, else 0.
- Latency is 1 cycle: sample presented at edge N gives out_data/out_valid valid after edge N.
- With continuous in_valid, out_valid stays high and results update every cycle.

Output gating:
- out_data = result register when out_en=1; all zeros when out_en=0.
- The gate is combinational and takes effect in the same cycle.
- out_valid, fill and full are not gated.

Fill status:
- fill increments by 1 per accepted sample until it reaches WIN, then holds.
- full asserts registered, on the edge where fill becomes WIN.

Idle and reset mid-operation:
- With in_valid=0, all state holds and out_valid=0.
- Asserting rst_n low mid-stream zeroes everything immediately, without waiting for a clock edge.
- After release, the first accepted sample behaves as a fresh start (fill goes to 1).

Test Plan:
(Defaults assumed: CHANNELS=3, DATA_W=2, LOG2_WIN=2, out_en=1.)
1. Fill, sum mode: mode=0; 4 accepts of ch0=3, ch1=1, ch2=0.
   - ch0 out 3, 6, 9, 12; ch1 out 1, 2, 3, 4; ch2 out 0.
   - fill 1..4; full asserts after the 4th accept; out_valid pulses each cycle.
2. Slide and saturate: continue from scenario 1 with ch0=0 ×4.
   - ch0 out 9, 6, 3, 0; fill stays 4; no wrap.
   - Max-value check: 4 accepts of ch0=3 give ch0 out 12 (4'b1100), not wrapped.
3. Average mode: mode=1; window holds ch0 samples 3, 3, 2, 0 (sum 8).
   - ch0 out 2.
   - After 1 accept of ch0=3 from clear: ch0 out 0 (3>>2); after the 2nd accept: ch0 out 1 (6>>2).
4. Gating and idle:
   - out_en=0 with a valid result: out_data=0 in the same cycle; out_valid still pulses.
   - out_en back to 1: result reappears.
   - in_valid=0 for 5 cycles: out_data is stable and out_valid stays 0.
5. Clear priority: clr=1 and in_valid=1 in the same cycle with a full window.
   - Next cycle: fill=0, full=0, out_data=0, out_valid=0.
   - Next accept of ch0=2: ch0 out 2, fill=1.
6. Async reset mid-stream: drop rst_n between clock edges with fill=3.
   - out_data, fill and out_valid read 0 before the next edge.
   - After release, 1 accept of ch0=1 gives ch0 out 1, fill=1.
